// File: rtl/apb_sram_test_master.sv
// ---------------------------------------------------------------------------
// apb_sram_test_master
//
// APB3 master that stands in for a processor during board bring-up or BIST.
// It writes a data pattern to NUM_LOCATIONS words of an APB memory slave,
// reads them back, and reports how many transfers failed and where the first
// failure happened.
//
// Ports
//   PCLK, PRESETN      clock (rising edge), asynchronous active-low reset
//   start              begin a run; only honoured in IDLE
//   mode[1:0]          data pattern, latched with start:
//                        00 index, 01 ~index, 10 0x55../0xAA.. by index
//                        parity, 11 all ones
//   busy               high while a run is on the bus
//   done               one-cycle pulse at the end of a run (normal or abort)
//   err_count[15:0]    failed transfers, saturating at 0xFFFF
//   first_err_addr     PADDR of the first failed transfer, 0 if none
//   timeout_err        the run was aborted because PREADY stayed low
//   PSEL, PENABLE,
//   PWRITE, PADDR,
//   PWDATA             APB master outputs (all registered)
//   PRDATA, PREADY,
//   PSLVERR            APB slave response
// ---------------------------------------------------------------------------
module apb_sram_test_master #(
    parameter int unsigned APB_DWIDTH    = 32,    // 8, 16, 24 or 32
    parameter int unsigned APB_AWIDTH    = 17,
    parameter int unsigned NUM_LOCATIONS = 8192,  // >= 1
    parameter int unsigned ADDR_SCHEME   = 0,     // 0: step 4, 1: step 1
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned TIMEOUT       = 255    // >= 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_count,
    output logic [APB_AWIDTH-1:0] first_err_addr,
    output logic                  timeout_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_AWIDTH-1:0] PADDR,
    output logic [APB_DWIDTH-1:0] PWDATA,
    input  logic [APB_DWIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned IDX_W = (NUM_LOCATIONS > 1) ? $clog2(NUM_LOCATIONS) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned OFF_W = IDX_W + 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LOCATIONS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_ACCESS,
        RD_SETUP,
        RD_ACCESS,
        DONE
    } state_e;

    // Byte address of a word index; the sum wraps at APB_AWIDTH bits.
    function automatic logic [APB_AWIDTH-1:0] addr_of(input logic [IDX_W-1:0] idx);
        logic [OFF_W-1:0] off;
        if (ADDR_SCHEME == 0) off = {idx, 2'b00};
        else                  off = {2'b00, idx};
        return APB_AWIDTH'(BASE_ADDR) + APB_AWIDTH'(off);
    endfunction

    // Data word for an index under a given pattern mode.
    function automatic logic [APB_DWIDTH-1:0] pattern(input logic [IDX_W-1:0] idx,
                                                      input logic [1:0]       m);
        logic [APB_DWIDTH-1:0] ext;
        logic [APB_DWIDTH-1:0] res;
        ext = APB_DWIDTH'(idx);
        case (m)
            2'b00:   res = ext;
            2'b01:   res = ~ext;
            2'b10:   res = idx[0] ? {(APB_DWIDTH/2){2'b10}} : {(APB_DWIDTH/2){2'b01}};
            default: res = '1;
        endcase
        return res;
    endfunction

    // Control state
    state_e                state_q,   state_d;
    logic [IDX_W-1:0]      index_q,   index_d;
    logic [1:0]            mode_q,    mode_d;
    logic [TMO_W-1:0]      wait_q,    wait_d;

    // Result registers (drive the result outputs directly)
    logic [15:0]           err_q,     err_d;
    logic [APB_AWIDTH-1:0] first_q,   first_d;
    logic                  tout_q,    tout_d;

    // Registered bus/status outputs, computed from the next state
    logic                  psel_q,    psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q,  pwrite_d;
    logic [APB_AWIDTH-1:0] paddr_q,   paddr_d;
    logic [APB_DWIDTH-1:0] pwdata_q,  pwdata_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic                  err_hit;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        index_d = index_q;
        mode_d  = mode_q;
        wait_d  = wait_q;
        err_d   = err_q;
        first_d = first_q;
        tout_d  = tout_q;
        err_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WR_SETUP;
                    index_d = '0;
                    mode_d  = mode;
                    err_d   = '0;
                    first_d = '0;
                    tout_d  = 1'b0;
                end
            end

            WR_SETUP: begin
                wait_d  = '0;
                state_d = WR_ACCESS;
            end

            WR_ACCESS: begin
                if (PREADY) begin
                    err_hit = PSLVERR;
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = RD_SETUP;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = WR_SETUP;
                    end
                end else if (wait_q == TMO_LAST) begin
                    // Abandon the stalled transfer without counting it.
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end

            RD_SETUP: begin
                wait_d  = '0;
                state_d = RD_ACCESS;
            end

            RD_ACCESS: begin
                if (PREADY) begin
                    // A slave error and a data miscompare on the same beat
                    // count once.
                    err_hit = PSLVERR || (PRDATA != pattern(index_q, mode_q));
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = RD_SETUP;
                    end
                end else if (wait_q == TMO_LAST) begin
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end

            DONE: begin
                // start is deliberately ignored here; restart only from IDLE.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (err_hit) begin
            if (err_q == '0)    first_d = paddr_q;
            if (err_q != '1)    err_d   = err_q + 16'd1;
        end

        psel_d    = state_d inside {WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS};
        penable_d = state_d inside {WR_ACCESS, RD_ACCESS};
        pwrite_d  = state_d inside {WR_SETUP, WR_ACCESS};
        busy_d    = psel_d;
        done_d    = (state_d == DONE);

        // Address and write data only change when a new SETUP begins, which
        // keeps them stable across any number of wait states.
        paddr_d  = (state_d inside {WR_SETUP, RD_SETUP}) ? addr_of(index_d) : paddr_q;
        pwdata_d = (state_d == WR_SETUP) ? pattern(index_d, mode_d) : pwdata_q;
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= IDLE;
            index_q   <= '0;
            mode_q    <= '0;
            wait_q    <= '0;
            err_q     <= '0;
            first_q   <= '0;
            tout_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            index_q   <= index_d;
            mode_q    <= mode_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            first_q   <= first_d;
            tout_q    <= tout_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign PSEL           = psel_q;
    assign PENABLE        = penable_q;
    assign PWRITE         = pwrite_q;
    assign PADDR          = paddr_q;
    assign PWDATA         = pwdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign timeout_err    = tout_q;

endmodule
